instr_issue_ctrl: RTL and testbench

INSTR_ISSUE_CTRL -- requirements
Module: instr_issue_ctrl

---
 rtl/instr_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_instr_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// instr_issue_ctrl
// Single-issue instruction sequencer. Accepts one instruction word in IDLE,
// decodes its fields into registered selects, runs one EXEC cycle (or starts
// the divider and waits for it with a timeout), then spends one WB cycle
// issuing the register-file write strobe, any exception and retiring (pc+1).
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   instr_valid/instr  : instruction word {opcode, rd, rs2, rs1}
//   instr_ready        : high while IDLE; handshake = valid && ready at edge
//   op_opcode          : latched opcode to the FU demux / result mux
//   rs1_sel, rs2_sel   : latched source register selects
//   imm_val            : zero-extended instr[7:0] (immediate for li)
//   co, m_co           : add carry-out / multiplier overflow, sampled in EXEC
//   div_start          : one-cycle divider start pulse (high during EXEC)
//   div_done           : divider result valid, sampled in DIV_WAIT
//   rd_wr_en, rd_sel   : register-file write strobe (WB only) and destination
//   pc                 : retired-instruction counter, wraps at 256
//   exc_valid/exc_code : exception pulse in WB: 0 carry, 1 mul ovf,
//                        2 div timeout, 3 illegal opcode
// ---------------------------------------------------------------------------
module instr_issue_ctrl #(
    parameter int unsigned N       = 16,
    parameter int unsigned SEL     = 4,
    parameter int unsigned DIV_TMO = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    input  logic [N-1:0]   instr,
    output logic           instr_ready,
    output logic [3:0]     op_opcode,
    output logic [SEL-1:0] rs1_sel,
    output logic [SEL-1:0] rs2_sel,
    output logic [N-1:0]   imm_val,
    input  logic           co,
    input  logic           m_co,
    output logic           div_start,
    input  logic           div_done,
    output logic           rd_wr_en,
    output logic [SEL-1:0] rd_sel,
    output logic [7:0]     pc,
    output logic           exc_valid,
    output logic [1:0]     exc_code
);

    // Divider wait counter is at least 5 bits wide and can always hold DIV_TMO.
    localparam int unsigned CNT_W = ($clog2(DIV_TMO + 1) > 5) ? $clog2(DIV_TMO + 1) : 5;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DIV_TMO - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    localparam logic [1:0] EXC_CARRY   = 2'd0;
    localparam logic [1:0] EXC_MUL_OVF = 2'd1;
    localparam logic [1:0] EXC_DIV_TMO = 2'd2;
    localparam logic [1:0] EXC_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EXEC     = 2'd1,
        S_DIV_WAIT = 2'd2,
        S_WB       = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] div_cnt;

    logic             handshake;
    logic             is_illegal;
    logic             write_allowed;

    // Ready is withheld while rst is high so nothing is accepted during reset.
    assign instr_ready   = (state == S_IDLE) && !rst;
    assign handshake     = instr_valid && instr_ready;

    // Opcodes 8..15 are illegal; x0 is hard-wired zero and never written.
    assign is_illegal    = op_opcode[3];
    assign write_allowed = (rd_sel != '0) && !is_illegal;

    // Sequencer: state, latched fields, strobes and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            op_opcode <= '0;
            rs1_sel   <= '0;
            rs2_sel   <= '0;
            rd_sel    <= '0;
            imm_val   <= '0;
            div_start <= 1'b0;
            rd_wr_en  <= 1'b0;
            exc_valid <= 1'b0;
            exc_code  <= '0;
            pc        <= '0;
        end else begin
            div_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (handshake) begin
                        op_opcode <= instr[15:12];
                        rd_sel    <= SEL'(instr[11:8]);
                        rs2_sel   <= SEL'(instr[7:4]);
                        rs1_sel   <= SEL'(instr[3:0]);
                        imm_val   <= N'(instr[7:0]);
                        // Start pulse lines up with the EXEC cycle.
                        div_start <= (instr[15:12] == OP_DIV);
                        state     <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (op_opcode == OP_DIV) begin
                        div_cnt <= '0;
                        state   <= S_DIV_WAIT;
                    end else begin
                        rd_wr_en <= write_allowed;
                        if (is_illegal) begin
                            exc_valid <= 1'b1;
                            exc_code  <= EXC_ILLEGAL;
                        end else if ((op_opcode == OP_ADD) && co) begin
                            exc_valid <= 1'b1;
                            exc_code  <= EXC_CARRY;
                        end else if ((op_opcode == OP_MUL) && m_co) begin
                            exc_valid <= 1'b1;
                            exc_code  <= EXC_MUL_OVF;
                        end
                        pc    <= pc + 8'd1;
                        state <= S_WB;
                    end
                end

                S_DIV_WAIT: begin
                    // div_done takes priority over a timeout in the same cycle.
                    if (div_done) begin
                        rd_wr_en <= write_allowed;
                        pc       <= pc + 8'd1;
                        state    <= S_WB;
                    end else if (div_cnt == TMO_LAST) begin
                        exc_valid <= 1'b1;
                        exc_code  <= EXC_DIV_TMO;
                        pc        <= pc + 8'd1;
                        state     <= S_WB;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end

                S_WB: begin
                    rd_wr_en  <= 1'b0;
                    exc_valid <= 1'b0;
                    exc_code  <= '0;
                    div_cnt   <= '0;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instr_issue_ctrl
// Table-driven bench for instr_issue_ctrl. Each issued instruction pushes its
// expected writeback onto a scoreboard queue; a negedge monitor pops and
// compares whenever pc advances (one retirement per WB cycle).
// ---------------------------------------------------------------------------
module tb_instr_issue_ctrl;

    localparam int unsigned N       = 16;
    localparam int unsigned SEL     = 4;
    localparam int unsigned DIV_TMO = 32;

    logic           clk;
    logic           rst;
    logic           instr_valid;
    logic [N-1:0]   instr;
    logic           instr_ready;
    logic [3:0]     op_opcode;
    logic [SEL-1:0] rs1_sel;
    logic [SEL-1:0] rs2_sel;
    logic [N-1:0]   imm_val;
    logic           co;
    logic           m_co;
    logic           div_start;
    logic           div_done;
    logic           rd_wr_en;
    logic [SEL-1:0] rd_sel;
    logic [7:0]     pc;
    logic           exc_valid;
    logic [1:0]     exc_code;

    instr_issue_ctrl #(.N(N), .SEL(SEL), .DIV_TMO(DIV_TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .op_opcode   (op_opcode),
        .rs1_sel     (rs1_sel),
        .rs2_sel     (rs2_sel),
        .imm_val     (imm_val),
        .co          (co),
        .m_co        (m_co),
        .div_start   (div_start),
        .div_done    (div_done),
        .rd_wr_en    (rd_wr_en),
        .rd_sel      (rd_sel),
        .pc          (pc),
        .exc_valid   (exc_valid),
        .exc_code    (exc_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // One table row: stimulus plus expected writeback and latency.
    // div_delay = DIV_WAIT cycle in which div_done is raised (0 = never).
    // lat = clock edges from handshake+1 up to and including the WB entry edge.
    typedef struct {
        logic [15:0] instr;
        logic        co;
        logic        m_co;
        int          div_delay;
        logic        wr;
        logic [3:0]  rd;
        logic        exc;
        logic [1:0]  code;
        int          lat;
    } vec_t;

    typedef struct {
        logic       wr;
        logic [3:0] rd;
        logic       exc;
        logic [1:0] code;
        logic [7:0] pc;
    } exp_t;

    vec_t       vecs[$];
    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] model_pc = 8'd0;
    logic [7:0] prev_pc  = 8'd0;

    // Scoreboard monitor: a pc change marks a retirement (WB cycle).
    always @(negedge clk) begin
        if (rst) begin
            prev_pc <= pc;
        end else if (pc != prev_pc) begin
            if (exp_q.size() == 0) begin
                chk("retire_without_issue", 32'(pc), 32'(prev_pc));
            end else begin
                mon_e = exp_q.pop_front();
                chk("wb_rd_wr_en", 32'(rd_wr_en), 32'(mon_e.wr));
                chk("wb_rd_sel", 32'(rd_sel), 32'(mon_e.rd));
                chk("wb_exc_valid", 32'(exc_valid), 32'(mon_e.exc));
                if (mon_e.exc)
                    chk("wb_exc_code", 32'(exc_code), 32'(mon_e.code));
                chk("wb_pc", 32'(pc), 32'(mon_e.pc));
            end
            prev_pc <= pc;
        end else begin
            chk("no_wb_rd_wr_en", 32'(rd_wr_en), 32'd0);
            chk("no_wb_exc_valid", 32'(exc_valid), 32'd0);
            prev_pc <= pc;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_instr_ready", 32'(instr_ready), 32'd0);
        chk("rst_op_opcode", 32'(op_opcode), 32'd0);
        chk("rst_rs1_sel", 32'(rs1_sel), 32'd0);
        chk("rst_rs2_sel", 32'(rs2_sel), 32'd0);
        chk("rst_imm_val", 32'(imm_val), 32'd0);
        chk("rst_div_start", 32'(div_start), 32'd0);
        chk("rst_rd_wr_en", 32'(rd_wr_en), 32'd0);
        chk("rst_rd_sel", 32'(rd_sel), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_exc_valid", 32'(exc_valid), 32'd0);
        chk("rst_exc_code", 32'(exc_code), 32'd0);
    endtask

    // Issue one table vector, check decode, latency and field stability.
    task automatic run_vec(input vec_t v);
        int         w;
        int         lat;
        logic [7:0] pc0;
        logic [3:0] opc;
        exp_t       e;
        opc = v.instr[15:12];
        w = 0;
        while (!instr_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_before_issue", 32'(instr_ready), 32'd1);
        instr_valid = 1'b1;
        instr       = v.instr;
        co          = v.co;
        m_co        = v.m_co;
        div_done    = 1'b0;
        @(posedge clk);
        e.wr = v.wr; e.rd = v.rd; e.exc = v.exc; e.code = v.code; e.pc = model_pc + 8'd1;
        exp_q.push_back(e);
        model_pc = model_pc + 8'd1;
        #1;
        instr_valid = 1'b0;
        instr       = 16'hFFFF;
        chk("exec_ready_low", 32'(instr_ready), 32'd0);
        chk("exec_op_opcode", 32'(op_opcode), 32'(opc));
        chk("exec_rd_sel", 32'(rd_sel), 32'(v.instr[11:8]));
        chk("exec_rs2_sel", 32'(rs2_sel), 32'(v.instr[7:4]));
        chk("exec_rs1_sel", 32'(rs1_sel), 32'(v.instr[3:0]));
        chk("exec_imm_val", 32'(imm_val), 32'(v.instr[7:0]));
        chk("exec_div_start", 32'(div_start), 32'(opc == 4'd3));
        lat = 0;
        pc0 = pc;
        while (pc == pc0 && lat < int'(DIV_TMO) + 10) begin
            div_done = (v.div_delay > 0) && (lat == v.div_delay);
            @(posedge clk); #1;
            lat++;
            if (lat == 1 && opc == 4'd3)
                chk("div_start_one_pulse", 32'(div_start), 32'd0);
        end
        div_done = 1'b0;
        chk("wb_latency", 32'(lat), 32'(v.lat));
        chk("hold_op_opcode", 32'(op_opcode), 32'(opc));
        chk("hold_rs1_sel", 32'(rs1_sel), 32'(v.instr[3:0]));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int hs;
        int last_hs;
        exp_t e;

        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        co          = 1'b0;
        m_co        = 1'b0;
        div_done    = 1'b0;

        //        instr     co    m_co  dly wr    rd     exc   code  lat
        vecs.push_back('{16'h0321, 1'b0, 1'b0, 0, 1'b1, 4'd3, 1'b0, 2'd0, 1});
        vecs.push_back('{16'h0321, 1'b1, 1'b0, 0, 1'b1, 4'd3, 1'b1, 2'd0, 1});
        vecs.push_back('{16'h2521, 1'b0, 1'b1, 0, 1'b1, 4'd5, 1'b1, 2'd1, 1});
        vecs.push_back('{16'h2521, 1'b1, 1'b0, 0, 1'b1, 4'd5, 1'b0, 2'd0, 1});
        vecs.push_back('{16'h1456, 1'b1, 1'b1, 0, 1'b1, 4'd4, 1'b0, 2'd0, 1});
        vecs.push_back('{16'h3742, 1'b0, 1'b0, 5, 1'b1, 4'd7, 1'b0, 2'd0, 6});
        vecs.push_back('{16'h3742, 1'b0, 1'b0, 0, 1'b0, 4'd7, 1'b1, 2'd2, int'(DIV_TMO) + 1});
        vecs.push_back('{16'h3742, 1'b0, 1'b0, int'(DIV_TMO), 1'b1, 4'd7, 1'b0, 2'd0, int'(DIV_TMO) + 1});
        vecs.push_back('{16'h3742, 1'b0, 1'b0, 1, 1'b1, 4'd7, 1'b0, 2'd0, 2});
        vecs.push_back('{16'h3042, 1'b0, 1'b0, 2, 1'b0, 4'd0, 1'b0, 2'd0, 3});
        vecs.push_back('{16'h7A2C, 1'b0, 1'b0, 0, 1'b1, 4'd10, 1'b0, 2'd0, 1});
        vecs.push_back('{16'h9123, 1'b0, 1'b0, 0, 1'b0, 4'd1, 1'b1, 2'd3, 1});
        vecs.push_back('{16'hF5AA, 1'b1, 1'b1, 0, 1'b0, 4'd5, 1'b1, 2'd3, 1});
        vecs.push_back('{16'h0012, 1'b0, 1'b0, 0, 1'b0, 4'd0, 1'b0, 2'd0, 1});
        vecs.push_back('{16'h4F00, 1'b0, 1'b0, 0, 1'b1, 4'd15, 1'b0, 2'd0, 1});
        vecs.push_back('{16'h6BCD, 1'b0, 1'b0, 0, 1'b1, 4'd11, 1'b0, 2'd0, 1});
        vecs.push_back('{16'h5E9F, 1'b0, 1'b0, 0, 1'b1, 4'd14, 1'b0, 2'd0, 1});

        // Power-on reset held across two edges.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Table vectors; the first one issues on the first edge after release.
        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i]);

        // Reset in the middle of DIV_WAIT discards the divide in flight.
        w = 0;
        while (!instr_ready && w < 10) begin
            @(posedge clk); #1;
            w++;
        end
        instr_valid = 1'b1;
        instr       = 16'h3742;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_reset_outputs();
        exp_q.delete();
        model_pc = 8'd0;
        @(posedge clk); #1;
        rst      = 1'b0;
        div_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_pc", 32'(pc), 32'd0);
        chk("post_rst_ready", 32'(instr_ready), 32'd1);
        chk("post_rst_no_write", 32'(rd_wr_en), 32'd0);
        div_done = 1'b0;
        run_vec(vecs[0]);

        // Back-to-back issue with instr_valid held high; pc wraps once.
        co      = 1'b0;
        m_co    = 1'b0;
        last_hs = 0;
        instr_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            w = 0;
            while (!instr_ready && w < 10) begin
                @(posedge clk); #1;
                w++;
            end
            instr = {4'h5, 4'((i % 15) + 1), 4'h2, 4'h1};
            @(posedge clk);
            e.wr = 1'b1; e.rd = 4'((i % 15) + 1); e.exc = 1'b0; e.code = 2'd0; e.pc = model_pc + 8'd1;
            exp_q.push_back(e);
            model_pc = model_pc + 8'd1;
            #1;
            hs = cyc;
            if (i > 0)
                chk("issue_gap", 32'(hs - last_hs), 32'd3);
            last_hs = hs;
        end
        instr_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("final_pc", 32'(pc), 32'(model_pc));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
